// File: rtl/uno_pkg.sv
// Shared UNO card types, constants and the player-hand FSM state encoding.
package uno_pkg;

  typedef struct packed {
    logic [1:0] color;
    logic [3:0] value;
  } card_t;

  localparam logic [1:0] RED    = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] BLUE   = 2'd3;

  localparam logic [3:0] VAL_SKIP  = 4'd10;
  localparam logic [3:0] VAL_REV   = 4'd11;
  localparam logic [3:0] VAL_DRAW2 = 4'd12;
  localparam logic [3:0] VAL_WILD  = 4'd13;
  localparam logic [3:0] VAL_WILD4 = 4'd14;

  // One-hot draw codes; the code's numeric value equals the card count.
  localparam logic [2:0] DRAW_ONE  = 3'b001;
  localparam logic [2:0] DRAW_TWO  = 3'b010;
  localparam logic [2:0] DRAW_FOUR = 3'b100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_CHECK,
    S_REMOVE
  } hand_state_t;

  function automatic logic is_draw_code(input logic [2:0] code);
    return (code == DRAW_ONE) || (code == DRAW_TWO) || (code == DRAW_FOUR);
  endfunction

endpackage

// File: rtl/card_legal_check.sv
// Combinational UNO legality check: wilds always play, otherwise the card
// must match the active colour or the top card's value.
module card_legal_check
  import uno_pkg::*;
(
  input  card_t      i_card,
  input  card_t      i_top,
  input  logic [1:0] i_cur_color,
  output logic       o_legal
);

  // Top card colour is superseded by i_cur_color (which tracks wild choices).
  logic unused_top_color;
  assign unused_top_color = ^i_top.color;

  // Legality decision.
  always_comb begin
    o_legal = (i_card.value >= VAL_WILD)
           || (i_card.color == i_cur_color)
           || (i_card.value == i_top.value);
  end

endmodule

// File: rtl/player_hand.sv
// Player hand: requests draws from the deck, stores dealt cards in a
// compacted array, and validates/removes played cards.
// Optional macro HAND_UNO_PENALTY_EN adds i_uno_call and an automatic
// draw-two penalty when a play leaves one card without an UNO call.
module player_hand
  import uno_pkg::*;
#(
  parameter int unsigned MAX_CARDS = 32,
  parameter int unsigned IDX_W     = 5
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [2:0]       i_req_draw,
  input  logic             i_deck_done,
  output logic [2:0]       o_draw,
  input  logic             i_drawn,
  input  logic [5:0]       i_card,
  input  logic             i_play,
  input  logic [IDX_W-1:0] i_play_idx,
  input  logic [5:0]       i_top_card,
  input  logic [1:0]       i_cur_color,
`ifdef HAND_UNO_PENALTY_EN
  input  logic             i_uno_call,
`endif
  output logic             o_play_ok,
  output logic             o_play_rej,
  output logic [5:0]       o_played_card,
  output logic [IDX_W:0]   o_count,
  output logic             o_empty,
  output logic             o_busy,
  output logic             o_overflow
);

  localparam logic [IDX_W:0] CNT_ONE = 1;
  localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(MAX_CARDS);

  hand_state_t      state;
  card_t            slots [MAX_CARDS];
  logic [IDX_W:0]   count;
  logic [IDX_W-1:0] idx_q;
  logic [2:0]       draw_q;
  logic [2:0]       recv_cnt;
  logic             play_ok_q;
  logic             play_rej_q;
  logic             overflow_q;
  card_t            played_q;
`ifdef HAND_UNO_PENALTY_EN
  logic             uno_q;
  logic             pend_q;
`endif

  card_t            sel_card;
  logic             sel_legal;
  logic             idx_valid;
  logic             has_room;
  logic [IDX_W:0]   count_dec;
  logic [IDX_W-1:0] top_idx;
  logic [2:0]       recv_next;

  assign sel_card  = slots[idx_q];
  assign idx_valid = ({1'b0, idx_q} < count);
  assign has_room  = (count < CNT_MAX);
  assign count_dec = count - CNT_ONE;
  assign top_idx   = IDX_W'(count_dec);
  assign recv_next = recv_cnt + 3'd1;

  card_legal_check u_legal (
    .i_card      (sel_card),
    .i_top       (i_top_card),
    .i_cur_color (i_cur_color),
    .o_legal     (sel_legal)
  );

  // Hand FSM with registered handshake outputs and the card storage array.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      count      <= '0;
      idx_q      <= '0;
      draw_q     <= '0;
      recv_cnt   <= '0;
      play_ok_q  <= 1'b0;
      play_rej_q <= 1'b0;
      overflow_q <= 1'b0;
      played_q   <= '0;
`ifdef HAND_UNO_PENALTY_EN
      uno_q      <= 1'b0;
      pend_q     <= 1'b0;
`endif
      for (int unsigned i = 0; i < MAX_CARDS; i++) begin
        slots[i] <= '0;
      end
    end else begin
      play_ok_q  <= 1'b0;
      play_rej_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
`ifdef HAND_UNO_PENALTY_EN
          if (pend_q) begin
            if (i_deck_done) begin
              draw_q   <= DRAW_TWO;
              recv_cnt <= '0;
              pend_q   <= 1'b0;
              state    <= S_RECV;
            end
          end else
`endif
          if (is_draw_code(i_req_draw) && i_deck_done) begin
            draw_q   <= i_req_draw;
            recv_cnt <= '0;
            state    <= S_RECV;
          end else if (i_play) begin
            idx_q <= i_play_idx;
`ifdef HAND_UNO_PENALTY_EN
            uno_q <= i_uno_call;
`endif
            state <= S_CHECK;
          end
        end

        S_RECV: begin
          if (i_drawn) begin
            if (has_room) begin
              slots[IDX_W'(count)] <= i_card;
              count                <= count + CNT_ONE;
            end else begin
              overflow_q <= 1'b1;
            end
            recv_cnt <= recv_next;
            if (recv_next == draw_q) begin
              draw_q <= '0;
              state  <= S_IDLE;
            end
          end
        end

        // Removal is committed on the CHECK->REMOVE edge so that o_play_ok,
        // o_played_card and the shrunken count all appear in the REMOVE cycle.
        S_CHECK: begin
          if (idx_valid && sel_legal) begin
            played_q  <= sel_card;
            play_ok_q <= 1'b1;
            for (int unsigned i = 0; i < MAX_CARDS - 1; i++) begin
              if ((i >= 32'(idx_q)) && (i + 1 < 32'(count))) begin
                slots[i] <= slots[i+1];
              end
            end
            slots[top_idx] <= '0;
            count          <= count_dec;
`ifdef HAND_UNO_PENALTY_EN
            if ((count_dec == CNT_ONE) && !uno_q) begin
              pend_q <= 1'b1;
            end
`endif
            state <= S_REMOVE;
          end else begin
            play_rej_q <= 1'b1;
            state      <= S_IDLE;
          end
        end

        S_REMOVE: begin
`ifdef HAND_UNO_PENALTY_EN
          if (pend_q && i_deck_done) begin
            draw_q   <= DRAW_TWO;
            recv_cnt <= '0;
            pend_q   <= 1'b0;
            state    <= S_RECV;
          end else begin
            state <= S_IDLE;
          end
`else
          state <= S_IDLE;
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_draw        = draw_q;
  assign o_play_ok     = play_ok_q;
  assign o_play_rej    = play_rej_q;
  assign o_played_card = played_q;
  assign o_count       = count;
  assign o_empty       = (count == '0);
  assign o_busy        = (state != S_IDLE);
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_player_hand.sv
// Self-checking bench for player_hand: directed table of plays, hand-written
// multi-cycle corner cases, and randomized traffic against a queue model.
module tb_player_hand;

  localparam int MAX_CARDS = 32;
  localparam int IDX_W     = 5;

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic [2:0]       i_req_draw = '0;
  logic             i_deck_done = 1'b1;
  logic [2:0]       o_draw;
  logic             i_drawn = 1'b0;
  logic [5:0]       i_card = '0;
  logic             i_play = 1'b0;
  logic [IDX_W-1:0] i_play_idx = '0;
  logic [5:0]       i_top_card = '0;
  logic [1:0]       i_cur_color = '0;
  logic             o_play_ok;
  logic             o_play_rej;
  logic [5:0]       o_played_card;
  logic [IDX_W:0]   o_count;
  logic             o_empty;
  logic             o_busy;
  logic             o_overflow;

  player_hand #(.MAX_CARDS(MAX_CARDS), .IDX_W(IDX_W)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_req_draw    (i_req_draw),
    .i_deck_done   (i_deck_done),
    .o_draw        (o_draw),
    .i_drawn       (i_drawn),
    .i_card        (i_card),
    .i_play        (i_play),
    .i_play_idx    (i_play_idx),
    .i_top_card    (i_top_card),
    .i_cur_color   (i_cur_color),
`ifdef HAND_UNO_PENALTY_EN
    .i_uno_call    (1'b1),
`endif
    .o_play_ok     (o_play_ok),
    .o_play_rej    (o_play_rej),
    .o_played_card (o_played_card),
    .o_count       (o_count),
    .o_empty       (o_empty),
    .o_busy        (o_busy),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the hand as an ordered list plus the sticky overflow flag.
  logic [5:0] hand[$];
  bit         ovf_m = 0;

  typedef struct {
    int         idx;
    logic [5:0] top;
    logic [1:0] col;
    bit         exp_ok;
    logic [5:0] exp_card;
  } play_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_slots(input string tag);
    logic [5:0] act;
    logic [5:0] exp;
    for (int i = 0; i < MAX_CARDS; i++) begin
      act = dut.slots[i];
      exp = (i < hand.size()) ? hand[i] : 6'h00;
      chk($sformatf("%s_slot%0d", tag, i), act, exp);
    end
  endtask

  task automatic check_idle_state(input string tag);
    chk({tag, "_count"}, o_count, hand.size());
    chk({tag, "_empty"}, o_empty, hand.size() == 0);
    chk({tag, "_ovf"}, o_overflow, ovf_m);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_draw"}, o_draw, 0);
  endtask

  // Act as the deck: request a draw and deliver cards (cards[6k+:6] is card k).
  task automatic do_draw(input logic [2:0] code, input logic [23:0] cards, input int gap_max);
    int n;
    n = (code == 3'b001) ? 1 : (code == 3'b010) ? 2 : 4;
    @(negedge i_clk);
    i_req_draw  = code;
    i_deck_done = 1'b1;
    @(negedge i_clk);
    i_req_draw = '0;
    chk("draw_busy", o_busy, 1);
    chk("draw_code", o_draw, code);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge i_clk);
        chk("draw_hold", o_draw, code);
      end
      i_drawn = 1'b1;
      i_card  = cards[k*6 +: 6];
      @(negedge i_clk);
      i_drawn = 1'b0;
      if (hand.size() < MAX_CARDS) hand.push_back(cards[k*6 +: 6]);
      else ovf_m = 1;
      if (k < n - 1) chk("draw_mid", o_draw, code);
    end
    check_idle_state("draw_done");
    check_slots("draw");
  endtask

  // Issue a play; the table path supplies its own expectations.
  task automatic do_play(input int idx, input logic [5:0] top, input logic [1:0] col,
                         input bit use_tab, input bit t_ok, input logic [5:0] t_card);
    bit         valid, legal, e_ok;
    logic [5:0] sel, e_card;
    valid  = idx < hand.size();
    sel    = valid ? hand[idx] : 6'h00;
    legal  = (sel[3:0] >= 4'd13) || (sel[5:4] == col) || (sel[3:0] == top[3:0]);
    e_ok   = valid && legal;
    e_card = sel;
    if (use_tab) begin
      e_ok   = t_ok;
      e_card = t_card;
    end
    @(negedge i_clk);
    i_play      = 1'b1;
    i_play_idx  = IDX_W'(idx);
    i_top_card  = top;
    i_cur_color = col;
    @(negedge i_clk);
    i_play = 1'b0;
    chk("play_early_ok", o_play_ok, 0);
    chk("play_early_rej", o_play_rej, 0);
    chk("play_busy", o_busy, 1);
    @(negedge i_clk);
    chk("play_ok", o_play_ok, e_ok);
    chk("play_rej", o_play_rej, !e_ok);
    if (e_ok && valid) begin
      chk("played_card", o_played_card, e_card);
      hand.delete(idx);
    end
    chk("play_count", o_count, hand.size());
    chk("play_empty", o_empty, hand.size() == 0);
    @(negedge i_clk);
    chk("play_ok_pulse", o_play_ok, 0);
    chk("play_rej_pulse", o_play_rej, 0);
    chk("play_idle", o_busy, 0);
    check_slots("play");
  endtask

  play_vec_t tab[6];

  initial begin
    // Starting hand {05, 1C, 2D}; expectations worked out by hand.
    tab[0] = '{idx: 0, top: 6'h37, col: 2'd3, exp_ok: 0, exp_card: 6'h00};
    tab[1] = '{idx: 7, top: 6'h37, col: 2'd3, exp_ok: 0, exp_card: 6'h00};
    tab[2] = '{idx: 1, top: 6'h13, col: 2'd1, exp_ok: 1, exp_card: 6'h1C};
    tab[3] = '{idx: 1, top: 6'h37, col: 2'd3, exp_ok: 1, exp_card: 6'h2D};
    tab[4] = '{idx: 0, top: 6'h25, col: 2'd2, exp_ok: 1, exp_card: 6'h05};
    tab[5] = '{idx: 0, top: 6'h00, col: 2'd0, exp_ok: 0, exp_card: 6'h00};

    repeat (3) @(negedge i_clk);
    chk("rst_count", o_count, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_draw", o_draw, 0);
    chk("rst_busy", o_busy, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("rst_ok", o_play_ok, 0);
    chk("rst_rej", o_play_rej, 0);
    chk("rst_played", o_played_card, 0);
    check_idle_state("rst");
    check_slots("rst");

    // Draw two then one: hand {05, 1C, 2D}.
    do_draw(3'b010, {12'h0, 6'h1C, 6'h05}, 0);
    do_draw(3'b001, {18'h0, 6'h2D}, 2);

    foreach (tab[i]) do_play(tab[i].idx, tab[i].top, tab[i].col, 1, tab[i].exp_ok, tab[i].exp_card);

    // Simultaneous draw and play: draw wins, play is silently dropped.
    @(negedge i_clk);
    i_req_draw = 3'b001;
    i_play     = 1'b1;
    i_play_idx = '0;
    @(negedge i_clk);
    i_req_draw = '0;
    i_play     = 1'b0;
    chk("both_draw", o_draw, 3'b001);
    chk("both_ok0", o_play_ok, 0);
    chk("both_rej0", o_play_rej, 0);
    i_drawn = 1'b1;
    i_card  = 6'h0A;
    @(negedge i_clk);
    i_drawn = 1'b0;
    hand.push_back(6'h0A);
    chk("both_ok1", o_play_ok, 0);
    chk("both_rej1", o_play_rej, 0);
    repeat (2) begin
      @(negedge i_clk);
      chk("both_ok2", o_play_ok, 0);
      chk("both_rej2", o_play_rej, 0);
    end
    check_idle_state("both");

    // Draw request while deck busy, and a malformed code, are both ignored.
    @(negedge i_clk);
    i_req_draw  = 3'b100;
    i_deck_done = 1'b0;
    @(negedge i_clk);
    i_req_draw  = 3'b011;
    i_deck_done = 1'b1;
    chk("nodeck_busy", o_busy, 0);
    @(negedge i_clk);
    i_req_draw = '0;
    chk("badcode_busy", o_busy, 0);
    check_idle_state("ignore");

    // Fill to capacity (1 + 7*4 + 2 + 1 = 32), then overflow with four more.
    repeat (7) do_draw(3'b100, 24'($urandom), 1);
    do_draw(3'b010, 24'($urandom), 1);
    do_draw(3'b001, 24'($urandom), 1);
    chk("full_count", o_count, 32);
    chk("full_ovf0", o_overflow, 0);
    do_draw(3'b100, 24'($urandom), 1);
    chk("ovf_count", o_count, 32);
    chk("ovf_flag", o_overflow, 1);
    do_play(31, 6'h00, 2'd0, 0, 0, 6'h00);
    do_play(0, 6'h00, 2'd0, 0, 0, 6'h00);

    // Asynchronous reset after one card of a four-card draw.
    while (hand.size() > 28) do_play($urandom_range(0, hand.size() - 1), 6'h0D, 2'($urandom), 0, 0, 6'h00);
    @(negedge i_clk);
    i_req_draw = 3'b100;
    @(negedge i_clk);
    i_req_draw = '0;
    i_drawn = 1'b1;
    i_card  = 6'h11;
    @(negedge i_clk);
    i_drawn = 1'b0;
    hand.push_back(6'h11);
    chk("mid_count", o_count, hand.size());
    chk("mid_draw", o_draw, 3'b100);
    #2 i_rst_n = 1'b0;
    #1;
    hand.delete();
    ovf_m = 0;
    chk("arst_count", o_count, 0);
    chk("arst_draw", o_draw, 0);
    chk("arst_empty", o_empty, 1);
    chk("arst_busy", o_busy, 0);
    chk("arst_ovf", o_overflow, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check_idle_state("arst");
    check_slots("arst");

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 30 && hand.size() <= 28) begin
        case ($urandom_range(0, 2))
          0:       do_draw(3'b001, 24'($urandom), 2);
          1:       do_draw(3'b010, 24'($urandom), 2);
          default: do_draw(3'b100, 24'($urandom), 2);
        endcase
      end else if (r < 35) begin
        @(negedge i_clk);
        i_req_draw  = 3'b010;
        i_deck_done = 1'b0;
        @(negedge i_clk);
        i_req_draw  = '0;
        i_deck_done = 1'b1;
        chk("rnd_nodeck", o_busy, 0);
      end else begin
        int idx;
        idx = $urandom_range(0, hand.size() + 1);
        if (idx > MAX_CARDS - 1) idx = MAX_CARDS - 1;
        do_play(idx, 6'($urandom), 2'($urandom), 0, 0, 6'h00);
      end
    end
    check_idle_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
